// File: rtl/addr_seq_ctrl.sv
// rtl/addr_seq_ctrl.sv - strided 2D address sequencer
// Latches a descriptor, then streams a y_count-by-x_count address grid on a valid/ready port.
module addr_seq_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int STRIDE_W = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [STRIDE_W-1:0] cfg_x_stride,
  input  logic [STRIDE_W-1:0] cfg_y_stride,
  input  logic [CNT_W-1:0]    cfg_x_count,
  input  logic [CNT_W-1:0]    cfg_y_count,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                addr_valid,
  input  logic                addr_ready,
  output logic [ADDR_W-1:0]   addr,
  output logic                addr_last
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_base, r_addr, r_row_base;
  logic [STRIDE_W-1:0] r_x_stride, r_y_stride;
  logic [CNT_W-1:0]    r_x_count, r_y_count, r_x_idx, r_y_idx;
  logic                r_done, w_done_nxt;

  logic                w_cfg_load, w_hs, w_row_end, w_last;
  logic                w_launch, w_zero_start;
  logic [ADDR_W-1:0]   w_base;
  logic [CNT_W-1:0]    w_x_count, w_y_count;
  logic [ADDR_W-1:0]   w_x_step, w_y_step, w_next_row;

  assign w_cfg_load = cfg_valid & cfg_ready;

  // A descriptor written in the same cycle as start is the one that start uses.
  assign w_base    = w_cfg_load ? cfg_base    : r_base;
  assign w_x_count = w_cfg_load ? cfg_x_count : r_x_count;
  assign w_y_count = w_cfg_load ? cfg_y_count : r_y_count;

  assign w_launch     = (r_state == IDLE) & start & (w_x_count != '0) & (w_y_count != '0);
  assign w_zero_start = (r_state == IDLE) & start & ((w_x_count == '0) | (w_y_count == '0));

  assign w_x_step   = {{(ADDR_W-STRIDE_W){1'b0}}, r_x_stride};
  assign w_y_step   = {{(ADDR_W-STRIDE_W){1'b0}}, r_y_stride};
  assign w_next_row = r_row_base + w_y_step;

  assign w_hs      = addr_valid & addr_ready;
  assign w_row_end = (r_x_idx == r_x_count - CNT_W'(1));
  assign w_last    = w_row_end & (r_y_idx == r_y_count - CNT_W'(1));

  assign cfg_ready  = (r_state == IDLE);
  assign busy       = (r_state == RUN);
  assign addr_valid = (r_state == RUN);
  assign addr_last  = (r_state == RUN) & w_last;
  assign addr       = r_addr;
  assign done       = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_launch) w_state_nxt = RUN;
        if (w_zero_start) w_done_nxt = 1'b1;
      end
      RUN: begin
        // abort wins over a handshake in the same cycle and suppresses done
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (w_hs & w_last) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base     <= '0;
      r_x_stride <= '0;
      r_y_stride <= '0;
      r_x_count  <= '0;
      r_y_count  <= '0;
    end else if (w_cfg_load) begin
      r_base     <= cfg_base;
      r_x_stride <= cfg_x_stride;
      r_y_stride <= cfg_y_stride;
      r_x_count  <= cfg_x_count;
      r_y_count  <= cfg_y_count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_row_base <= '0;
      r_x_idx    <= '0;
      r_y_idx    <= '0;
    end else if (w_launch) begin
      r_addr     <= w_base;
      r_row_base <= w_base;
      r_x_idx    <= '0;
      r_y_idx    <= '0;
    end else if ((r_state == RUN) & ~abort & w_hs) begin
      if (w_row_end) begin
        r_row_base <= w_next_row;
        r_addr     <= w_next_row;
        r_x_idx    <= '0;
        r_y_idx    <= r_y_idx + CNT_W'(1);
      end else begin
        r_addr     <= r_addr + w_x_step;
        r_x_idx    <= r_x_idx + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// tb/tb_addr_seq_ctrl.sv - directed self-checking bench for addr_seq_ctrl
module tb_addr_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid, cfg_ready;
  logic [31:0] cfg_base;
  logic [15:0] cfg_x_stride, cfg_y_stride, cfg_x_count, cfg_y_count;
  logic        start, abort, busy, done;
  logic        addr_valid, addr_ready, addr_last;
  logic [31:0] addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  addr_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_base(cfg_base), .cfg_x_stride(cfg_x_stride), .cfg_y_stride(cfg_y_stride),
    .cfg_x_count(cfg_x_count), .cfg_y_count(cfg_y_count),
    .start(start), .abort(abort), .busy(busy), .done(done),
    .addr_valid(addr_valid), .addr_ready(addr_ready),
    .addr(addr), .addr_last(addr_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [31:0] b, input logic [15:0] xs, input logic [15:0] ys,
                          input logic [15:0] xc, input logic [15:0] yc);
    cfg_base = b; cfg_x_stride = xs; cfg_y_stride = ys;
    cfg_x_count = xc; cfg_y_count = yc;
  endtask

  logic [31:0] exp_a [6];
  int idx, hs_cnt, cyc;

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0; addr_ready = 1'b0;
    load_cfg(32'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    #12;
    check("rst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_valid", {31'b0, addr_valid}, 32'd0);
    check("rst_addr", addr, 32'h0);
    check("rst_last", {31'b0, addr_last}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // basic 3x2 grid
    exp_a = '{32'h100, 32'h104, 32'h108, 32'h140, 32'h144, 32'h148};
    load_cfg(32'h100, 16'd4, 16'h40, 16'd3, 16'd2);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b1; addr_ready = 1'b1;
    step();
    start = 1'b0;
    check("basic_busy", {31'b0, busy}, 32'd1);
    check("basic_cfg_ready", {31'b0, cfg_ready}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("basic_valid%0d", i), {31'b0, addr_valid}, 32'd1);
      check($sformatf("basic_addr%0d", i), addr, exp_a[i]);
      check($sformatf("basic_last%0d", i), {31'b0, addr_last}, (i == 5) ? 32'd1 : 32'd0);
      check($sformatf("basic_nodone%0d", i), {31'b0, done}, 32'd0);
      step();
    end
    check("basic_done", {31'b0, done}, 32'd1);
    check("basic_done_busy", {31'b0, busy}, 32'd0);
    check("basic_done_valid", {31'b0, addr_valid}, 32'd0);
    step();
    check("basic_done_once", {31'b0, done}, 32'd0);

    // backpressure, descriptor reused
    start = 1'b1;
    step();
    start = 1'b0;
    idx = 0; hs_cnt = 0; cyc = 0;
    while (idx < 6 && cyc < 40) begin
      addr_ready = (cyc % 3 == 0);
      check($sformatf("bp_valid_c%0d", cyc), {31'b0, addr_valid}, 32'd1);
      check($sformatf("bp_addr_c%0d", cyc), addr, exp_a[idx]);
      check($sformatf("bp_last_c%0d", cyc), {31'b0, addr_last}, (idx == 5) ? 32'd1 : 32'd0);
      if (addr_ready && addr_valid) hs_cnt++;
      step();
      if (addr_ready) idx++;
      cyc++;
    end
    check("bp_handshakes", hs_cnt, 32'd6);
    check("bp_done", {31'b0, done}, 32'd1);
    addr_ready = 1'b1;
    step();

    // zero count with same-cycle cfg write
    load_cfg(32'h300, 16'd4, 16'd4, 16'd0, 16'd5);
    cfg_valid = 1'b1; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    check("zero_valid", {31'b0, addr_valid}, 32'd0);
    check("zero_busy", {31'b0, busy}, 32'd0);
    check("zero_done", {31'b0, done}, 32'd1);
    step();
    check("zero_done_once", {31'b0, done}, 32'd0);
    check("zero_valid2", {31'b0, addr_valid}, 32'd0);

    // wrap-around
    load_cfg(32'hFFFF_FFF8, 16'd8, 16'd0, 16'd3, 16'd1);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'h0; exp_a[2] = 32'h8;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wrap_addr%0d", i), addr, exp_a[i]);
      check($sformatf("wrap_last%0d", i), {31'b0, addr_last}, (i == 2) ? 32'd1 : 32'd0);
      step();
    end
    check("wrap_done", {31'b0, done}, 32'd1);
    step();

    // abort on 5th beat of a 4x4 grid with ready low
    load_cfg(32'h1000, 16'd1, 16'h10, 16'd4, 16'd4);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    addr_ready = 1'b0; abort = 1'b1;
    check("abort_beat5_addr", addr, 32'h1010);
    step();
    abort = 1'b0; addr_ready = 1'b1;
    check("abort_valid", {31'b0, addr_valid}, 32'd0);
    check("abort_last", {31'b0, addr_last}, 32'd0);
    check("abort_nodone", {31'b0, done}, 32'd0);
    check("abort_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    step();
    check("abort_nodone2", {31'b0, done}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("restart_addr%0d", i), addr, 32'h1000 + 32'((i / 4) * 16 + (i % 4)));
      check($sformatf("restart_last%0d", i), {31'b0, addr_last}, (i == 15) ? 32'd1 : 32'd0);
      step();
    end
    check("restart_done", {31'b0, done}, 32'd1);
    step();

    // same-cycle cfg+start, then reset mid-run
    load_cfg(32'h2000, 16'd4, 16'h100, 16'd2, 16'd2);
    cfg_valid = 1'b1; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    check("samecyc_addr0", addr, 32'h2000);
    step();
    check("samecyc_addr1", addr, 32'h2004);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'b0, addr_valid}, 32'd0);
    check("midrst_addr", addr, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    check("midrst_last", {31'b0, addr_last}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("lostdesc_valid", {31'b0, addr_valid}, 32'd0);
    check("lostdesc_done", {31'b0, done}, 32'd1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
